// File: rtl/axi_lite_frame_regs.sv
// AXI-Lite register bank with byte strobes, a read-only status window and SLVERR decode.
// `define AXIL_FRAME_REGS_SHADOW_EN to stage writes and apply them to regs_out only on frame_sync.
//
// write state     | meaning
// W_IDLE          | ready for AW and/or W
// W_AWAIT_WDATA   | address held, waiting for write data
// W_AWAIT_WADD    | data held, waiting for write address
// W_WRITE         | one-cycle commit of held data into the bank
// W_RESP          | bvalid held until bready
//
// read state      | meaning
// R_IDLE          | ready for AR
// R_FETCH         | register rdata/rresp from the decoded source
// R_READ          | rvalid held until rready
module axi_lite_frame_regs #(
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int REG_FILE_SIZE = 8,
  parameter int NUM_STATUS = 2,
  parameter logic [REG_FILE_SIZE*32-1:0] RESET_VALUES = {REG_FILE_SIZE*32{1'b0}}
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic [3:0]                     s_axi_lite_wstrb,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  input  logic                           frame_sync,
  input  logic [NUM_STATUS*32-1:0]       status_in,
  output logic [REG_FILE_SIZE*32-1:0]    regs_out,
  output logic                           update_pending
);

  localparam int AW = AXI_LITE_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_AWAIT_WDATA, W_AWAIT_WADD, W_WRITE, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_READ} rd_state_t;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic [AW-1:0] awaddr_q, araddr_q, wr_idx, rd_idx;
  logic [31:0]   wdata_q, rdata_q, rdata_d;
  logic [3:0]    wstrb_q;
  logic [1:0]    bresp_q, rresp_q, rresp_d;
  logic          aw_hs, w_hs, ar_hs, wr_hit, commit;
  logic [31:0]   active_q [REG_FILE_SIZE];
  logic [31:0]   rd_src [REG_FILE_SIZE];

  assign s_axi_lite_awready = (wr_state_q == W_IDLE) || (wr_state_q == W_AWAIT_WADD);
  assign s_axi_lite_wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_AWAIT_WDATA);
  assign s_axi_lite_bvalid  = (wr_state_q == W_RESP);
  assign s_axi_lite_bresp   = bresp_q;
  assign s_axi_lite_arready = (rd_state_q == R_IDLE);
  assign s_axi_lite_rvalid  = (rd_state_q == R_READ);
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = rresp_q;

  assign aw_hs  = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_hs   = s_axi_lite_wvalid && s_axi_lite_wready;
  assign ar_hs  = s_axi_lite_arvalid && s_axi_lite_arready;
  assign wr_idx = awaddr_q >> 2;
  assign rd_idx = araddr_q >> 2;
  assign wr_hit = wr_idx < AW'(REG_FILE_SIZE);
  assign commit = (wr_state_q == W_WRITE) && wr_hit;

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = W_WRITE;
        else if (aw_hs)    wr_state_d = W_AWAIT_WDATA;
        else if (w_hs)     wr_state_d = W_AWAIT_WADD;
      end
      W_AWAIT_WDATA: if (w_hs)  wr_state_d = W_WRITE;
      W_AWAIT_WADD:  if (aw_hs) wr_state_d = W_WRITE;
      W_WRITE:       wr_state_d = W_RESP;
      W_RESP:        if (s_axi_lite_bready) wr_state_d = W_IDLE;
      default:       wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_FETCH;
      R_FETCH: rd_state_d = R_READ;
      R_READ:  if (s_axi_lite_rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Status words alias above the RW registers; anything past them is unmapped.
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      if (rd_idx == AW'(i)) begin
        rdata_d = rd_src[i];
        rresp_d = RESP_OKAY;
      end
    end
    for (int s = 0; s < NUM_STATUS; s++) begin
      if (rd_idx == AW'(REG_FILE_SIZE + s)) begin
        rdata_d = status_in[32*s +: 32];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      if (aw_hs) awaddr_q <= s_axi_lite_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_lite_wdata;
        wstrb_q <= s_axi_lite_wstrb;
      end
      if (wr_state_q == W_WRITE) bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) araddr_q <= s_axi_lite_araddr;
      if (rd_state_q == R_FETCH) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end
  end

`ifdef AXIL_FRAME_REGS_SHADOW_EN
  logic [31:0] staged_q [REG_FILE_SIZE];
  logic        pending_q;

  // Nonblocking copy means a coincident commit lands in staged only, after active samples it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        staged_q[i] <= RESET_VALUES[32*i +: 32];
        active_q[i] <= RESET_VALUES[32*i +: 32];
      end
      pending_q <= 1'b0;
    end else begin
      if (frame_sync && pending_q) begin
        for (int i = 0; i < REG_FILE_SIZE; i++) active_q[i] <= staged_q[i];
      end
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (commit && (wr_idx == AW'(i)) && wstrb_q[k])
            staged_q[i][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
      if (commit)          pending_q <= 1'b1;
      else if (frame_sync) pending_q <= 1'b0;
    end
  end

  assign update_pending = pending_q;
  for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_rd_src
    assign rd_src[g] = staged_q[g];
  end
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) active_q[i] <= RESET_VALUES[32*i +: 32];
    end else begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (commit && (wr_idx == AW'(i)) && wstrb_q[k])
            active_q[i][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign update_pending = 1'b0;
  for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_rd_src
    assign rd_src[g] = active_q[g];
  end
`endif

  for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_regs_out
    assign regs_out[32*g +: 32] = active_q[g];
  end

endmodule

// File: tb/tb_axi_lite_frame_regs.sv
// Directed bench for axi_lite_frame_regs: a transaction-level register model is compared with
// regs_out/update_pending every cycle; handshakes, latency and responses are checked in the tasks.
`timescale 1ns/1ps
module tb_axi_lite_frame_regs;
  localparam int AW = 8;
  localparam int NR = 8;
  localparam int NS = 2;
  localparam logic [NR*32-1:0] RV = {32'hCAFE0007, 192'h0, 32'h00030500};

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [AW-1:0]     awaddr = '0, araddr = '0;
  logic              awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, frame_sync = 0;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              awready, wready, bvalid, arready, rvalid, update_pending;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata;
  logic [NS*32-1:0]  status_in = {32'h0BADF00D, 32'hDEADBEEF};
  logic [NR*32-1:0]  regs_out;

  always #5 aclk = ~aclk;

  axi_lite_frame_regs #(
    .AXI_LITE_ADDR_WIDTH(AW), .REG_FILE_SIZE(NR), .NUM_STATUS(NS), .RESET_VALUES(RV)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready), .frame_sync(frame_sync),
    .status_in(status_in), .regs_out(regs_out), .update_pending(update_pending)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  logic [31:0] m_staged [NR];
  logic [31:0] m_active [NR];
  logic        m_pending;

  function automatic logic [NR*32-1:0] m_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = m_active[i];
    return f;
  endfunction

  task automatic model_reset();
    logic [NR*32-1:0] rv;
    rv = RV;
    for (int i = 0; i < NR; i++) begin
      m_staged[i] = rv[32*i +: 32];
      m_active[i] = rv[32*i +: 32];
    end
    m_pending = 1'b0;
  endtask

  task automatic model_commit(input logic [AW-1:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    int idx;
    logic [31:0] w;
    idx = int'(addr) / 4;
    if (idx < NR) begin
`ifdef AXIL_FRAME_REGS_SHADOW_EN
      w = m_staged[idx];
`else
      w = m_active[idx];
`endif
      for (int k = 0; k < 4; k++) if (strb[k]) w[8*k +: 8] = data[8*k +: 8];
`ifdef AXIL_FRAME_REGS_SHADOW_EN
      m_staged[idx] = w;
      m_pending = 1'b1;
`else
      m_active[idx] = w;
`endif
    end
  endtask

  task automatic model_fs();
`ifdef AXIL_FRAME_REGS_SHADOW_EN
    if (m_pending) begin
      m_active = m_staged;
      m_pending = 1'b0;
    end
`endif
  endtask

  task automatic model_read(input logic [AW-1:0] addr, output logic [31:0] d,
                            output logic [1:0] r);
    int idx;
    idx = int'(addr) / 4;
    d = '0;
    r = 2'b10;
    if (idx < NR) begin
`ifdef AXIL_FRAME_REGS_SHADOW_EN
      d = m_staged[idx];
`else
      d = m_active[idx];
`endif
      r = 2'b00;
    end else if (idx < NR + NS) begin
      d = status_in[32*(idx-NR) +: 32];
      r = 2'b00;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (cmp_en) begin
      checks++;
      if (regs_out !== m_flat() || update_pending !== m_pending) begin
        errors++;
        $display("FAIL cycle_model at %0t: regs_out=%h required=%h pending=%b required=%b",
                 $time, regs_out, m_flat(), update_pending, m_pending);
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, input bit fs);
    int c;
    bit aw_done, w_done;
    logic [1:0] exp_resp;
    c = 0; aw_done = 0; w_done = 0;
    exp_resp = (int'(addr) / 4 < NR) ? 2'b00 : 2'b10;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && c < 40) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      chk("awready_open", awready, !aw_done);
      chk("wready_open", wready, !w_done);
      chk("bvalid_quiet", bvalid, 0);
      @(posedge aclk); #1;
      c++;
      if (awvalid) aw_done = 1;
      if (wvalid) w_done = 1;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) chk("write_handshake_timeout", 0, 1);
    frame_sync = fs;
    chk("bvalid_write_cycle", bvalid, 0);
    chk("awready_write_cycle", awready, 0);
    chk("wready_write_cycle", wready, 0);
    @(posedge aclk); #1;
    frame_sync = 0;
    if (fs) model_fs();
    model_commit(addr, data, strb);
    for (int i = 0; i <= b_dly; i++) begin
      chk("bvalid_held", bvalid, 1);
      chk("bresp", bresp, exp_resp);
      chk("awready_resp", awready, 0);
      chk("wready_resp", wready, 0);
      if (i == b_dly) bready = 1;
      @(posedge aclk); #1;
    end
    bready = 0;
    chk("bvalid_cleared", bvalid, 0);
    chk("awready_back", awready, 1);
    chk("wready_back", wready, 1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_dly, output logic [31:0] got);
    logic [31:0] ed;
    logic [1:0]  er;
    araddr = addr; arvalid = 1;
    chk("arready_idle", arready, 1);
    @(posedge aclk); #1;
    arvalid = 0;
    chk("rvalid_fetch", rvalid, 0);
    chk("arready_fetch", arready, 0);
    model_read(addr, ed, er);
    @(posedge aclk); #1;
    got = rdata;
    for (int i = 0; i <= r_dly; i++) begin
      chk("rvalid_held", rvalid, 1);
      chk("rdata", rdata, ed);
      chk("rresp", rresp, er);
      if (i == r_dly) rready = 1;
      @(posedge aclk); #1;
    end
    rready = 0;
    chk("rvalid_cleared", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  task automatic pulse_fs();
    frame_sync = 1;
    @(posedge aclk); #1;
    frame_sync = 0;
    model_fs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    model_reset();
    cmp_en = 1;
    #12;
    chk("reset_word0", regs_out[31:0], 32'h00030500);
    chk("reset_word7", regs_out[255:224], 32'hCAFE0007);
    chk("reset_pending", update_pending, 0);
    chk("reset_ready", {awready, wready, arready}, 3'b111);
    chk("reset_valid", {bvalid, rvalid}, 2'b00);
    @(posedge aclk); #1;
    aresetn = 1;

    axi_read(8'h04, 0, got);
    chk("read_word1_lit", got, 32'h0);

    axi_write(8'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
    axi_read(8'h00, 2, got);
    chk("strobe_read_lit", got, 32'h00BB05DD);
`ifdef AXIL_FRAME_REGS_SHADOW_EN
    chk("staged_not_active_lit", regs_out[31:0], 32'h00030500);
    chk("pending_set_lit", update_pending, 1);
`else
    chk("direct_write_lit", regs_out[31:0], 32'h00BB05DD);
    chk("pending_tied_lit", update_pending, 0);
`endif
    pulse_fs();
    chk("after_sync_lit", regs_out[31:0], 32'h00BB05DD);
    chk("after_sync_pending_lit", update_pending, 0);
    pulse_fs();
    chk("idle_sync_lit", regs_out[31:0], 32'h00BB05DD);

    axi_write(8'h08, 32'h12345678, 4'hF, 0, 3, 5, 0);
    axi_write(8'h0C, 32'h9ABCDEF0, 4'b1010, 2, 0, 0, 0);
    axi_write(8'h1C, 32'h76543210, 4'b0011, 1, 1, 1, 0);
    axi_read(8'h1C, 0, got);
    chk("last_reg_lit", got, 32'hCAFE3210);

    axi_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    axi_read(8'h20, 0, got);
    chk("status0_lit", got, 32'hDEADBEEF);
    axi_read(8'h24, 1, got);
    axi_read(8'h28, 0, got);
    axi_read(8'hFC, 0, got);
    axi_write(8'hFC, 32'h0, 4'hF, 0, 0, 0, 0);

    axi_write(8'h04, 32'h11111111, 4'hF, 0, 0, 0, 1);
`ifdef AXIL_FRAME_REGS_SHADOW_EN
    chk("coincident_word1_lit", regs_out[63:32], 32'h0);
    chk("coincident_pending_lit", update_pending, 1);
`else
    chk("coincident_word1_lit", regs_out[63:32], 32'h11111111);
`endif
    pulse_fs();
    chk("second_sync_word1_lit", regs_out[63:32], 32'h11111111);

    awaddr = 8'h08; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 8'h00; arvalid = 1;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge aclk); #1;
    model_commit(8'h08, 32'h5A5A5A5A, 4'hF);
    chk("both_valid", {bvalid, rvalid}, 2'b11);
    #2;
    aresetn = 0;
    model_reset();
    #1;
    chk("rst_drop_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_rdata", rdata, 0);
    chk("rst_regs_word0", regs_out[31:0], 32'h00030500);
    chk("rst_regs_word2", regs_out[95:64], 32'h0);
    chk("rst_pending", update_pending, 0);
    @(posedge aclk); #1;
    aresetn = 1;
    chk("rst_ready", {awready, wready, arready}, 3'b111);
    axi_read(8'h08, 0, got);
    chk("rst_no_commit_lit", got, 32'h0);

    @(posedge aclk); #1;
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
